remap_clksel_m: RTL and testbench

Parametrised remap and clock-select controller for the CPU-side CPLD. It decodes each 65816 bus cycle against NUM_WIN programmable 4KB-granular remap windows and a shadow of the BBC paged-ROM register, and emits the effective bank byte plus remap/dummy-access flags. It also runs a three-state HS/LS clock-select machine with a programmable LS dwell after BBC writes, and drives `hsclk_sel` to the clock controller.

---
 rtl/remap_clksel_m.sv | 179 +++++++++++++++++
 tb/tb_remap_clksel_m.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/remap_clksel_m.sv
// Bank remap windows, paged-ROM shadow and HS/LS clock-select FSM for the CPU-side CPLD.
// All decode is combinational on the current bus cycle; state updates on the cpu_clk rising edge.
module remap_clksel_m #(
  parameter int unsigned NUM_WIN     = 4,
  parameter int unsigned ROMSEL_SZ   = 4,
  parameter logic [15:0] ROMSEL_ADDR = 16'hFE30
) (
  input  logic        cpu_clk,
  input  logic        resetb,
  input  logic [15:0] addr,
  input  logic [7:0]  bank_in,
  input  logic        vda,
  input  logic        vpa,
  input  logic        rnw,
  input  logic [7:0]  data_in,
  output logic [7:0]  hiaddr_out,
  output logic        remap_hit,
  output logic        dummy_access,
  output logic        reg_rd_en,
  output logic [7:0]  reg_rd_data,
  output logic        hsclk_sel,
  output logic        hold_active
);

  typedef enum logic [1:0] {StLs = 2'd0, StHs = 2'd1, StHold = 2'd2} state_e;

  localparam logic [8:0] WinEnd = 9'(16 + 4 * NUM_WIN);

  logic                 r_ctrl_en;
  logic [7:0]           r_hold;
  logic [7:0]           r_cnt, w_cnt_d;
  logic [ROMSEL_SZ-1:0] r_romsel;
  state_e               r_state, w_state_d;
  logic [7:0]           r_win_src  [NUM_WIN];
  logic [7:0]           r_win_dest [NUM_WIN];
  logic [7:0]           r_win_cfg  [NUM_WIN];

  logic [7:0]         w_off;
  logic               w_reg, w_reg_wr, w_in_win, w_romsel_wr, w_bbc_write, w_hit, w_hsclk;
  logic [2:0]         w_widx;
  logic [7:0]         w_romsel8, w_dest, w_hiaddr, w_rd_data;
  logic [NUM_WIN-1:0] w_match;

  assign w_off       = addr[7:0];
  assign w_reg       = (bank_in[7:6] == 2'b10) && (addr[15:8] == 8'h00) && vda;
  assign w_reg_wr    = w_reg && !rnw;
  assign w_in_win    = (w_off >= 8'h10) && ({1'b0, w_off} < WinEnd);
  // Offsets 0x10..0x2F: bits [4:2] rotated by 4 give the window index.
  assign w_widx      = w_off[4:2] + 3'd4;
  assign w_romsel8   = 8'(r_romsel);
  assign w_romsel_wr = vda && !rnw && !bank_in[7] && (addr == ROMSEL_ADDR);

  always_comb begin
    w_match = '0;
    for (int i = 0; i < NUM_WIN; i++) begin
      w_match[i] = r_win_cfg[i][7] && !bank_in[7] && (vda || vpa) &&
                   (addr[15:12] >= r_win_src[i][3:0]) && (addr[15:12] <= r_win_src[i][7:4]) &&
                   (!r_win_cfg[i][5] || (w_romsel8[3:0] == r_win_cfg[i][3:0])) &&
                   (!r_win_cfg[i][6] || rnw);
    end
  end

  // Walk from the top so the lowest matching index is the last to assign.
  always_comb begin
    w_hit  = 1'b0;
    w_dest = 8'h00;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit  = 1'b1;
        w_dest = r_win_dest[i];
      end
    end
  end

  assign w_hiaddr    = w_hit ? w_dest : bank_in;
  assign w_bbc_write = vda && !rnw && !bank_in[7] && !w_hit && !w_reg;

  always_comb begin
    w_rd_data = 8'h00;
    if (w_in_win) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        if (w_widx == 3'(i)) begin
          case (w_off[1:0])
            2'd0:    w_rd_data = r_win_src[i];
            2'd1:    w_rd_data = r_win_dest[i];
            2'd2:    w_rd_data = r_win_cfg[i];
            default: w_rd_data = 8'h00;
          endcase
        end
      end
    end else begin
      case (w_off)
        8'h00:   w_rd_data = {7'b0, r_ctrl_en};
        8'h01:   w_rd_data = r_hold;
        8'h02:   w_rd_data = {6'b0, r_state};
        8'h03:   w_rd_data = w_romsel8;
        default: w_rd_data = 8'h00;
      endcase
    end
  end

  always_comb begin
    w_hsclk = 1'b0;
    if (!r_ctrl_en || (r_state == StHold)) begin
      w_hsclk = 1'b0;
    end else if (vpa && vda && rnw) begin
      w_hsclk = w_hiaddr[7];
    end else if (bank_in[7] && (vda || vpa)) begin
      w_hsclk = (r_state == StHs);
    end else if (w_hit && rnw) begin
      w_hsclk = (r_state == StHs);
    end else if (!vda && !vpa) begin
      w_hsclk = (r_state == StHs);
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    if (!r_ctrl_en) begin
      w_state_d = StLs;
      w_cnt_d   = 8'h00;
    end else if (w_bbc_write && (r_hold != 8'h00)) begin
      w_state_d = StHold;
      w_cnt_d   = r_hold - 8'h01;
    end else if (r_state == StHold) begin
      if (r_cnt == 8'h00) w_state_d = StLs;
      else                w_cnt_d   = r_cnt - 8'h01;
    end else begin
      w_state_d = w_hsclk ? StHs : StLs;
    end
  end

  always_ff @(posedge cpu_clk or negedge resetb) begin
    if (!resetb) begin
      r_state <= StLs;
      r_cnt   <= 8'h00;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_ff @(posedge cpu_clk or negedge resetb) begin
    if (!resetb) begin
      r_ctrl_en <= 1'b0;
      r_hold    <= 8'h00;
      r_romsel  <= '0;
      for (int i = 0; i < NUM_WIN; i++) begin
        r_win_src[i]  <= 8'h00;
        r_win_dest[i] <= 8'h00;
        r_win_cfg[i]  <= 8'h00;
      end
    end else begin
      if (w_reg_wr && (w_off == 8'h00)) r_ctrl_en <= data_in[0];
      if (w_reg_wr && (w_off == 8'h01)) r_hold    <= data_in;
      for (int i = 0; i < NUM_WIN; i++) begin
        if (w_reg_wr && w_in_win && (w_widx == 3'(i))) begin
          case (w_off[1:0])
            2'd0:    r_win_src[i]  <= data_in;
            2'd1:    r_win_dest[i] <= data_in;
            2'd2:    r_win_cfg[i]  <= {data_in[7:5], 1'b0, data_in[3:0]};
            default: ;
          endcase
        end
      end
      if (w_romsel_wr) r_romsel <= data_in[ROMSEL_SZ-1:0];
    end
  end

  assign hiaddr_out   = w_hiaddr;
  assign remap_hit    = w_hit;
  assign dummy_access = bank_in[7] && (vda || vpa);
  assign reg_rd_en    = w_reg && rnw;
  assign reg_rd_data  = w_rd_data;
  assign hsclk_sel    = w_hsclk;
  assign hold_active  = (r_state == StHold);

endmodule

// File: tb/tb_remap_clksel_m.sv
// Scoreboard bench for remap_clksel_m: each bus cycle queues its expected outputs,
// which are popped and compared at the falling edge of that cycle.
module tb_remap_clksel_m;

  logic        cpu_clk = 1'b0;
  logic        resetb  = 1'b0;
  logic [15:0] addr    = 16'h0000;
  logic [7:0]  bank_in = 8'h00;
  logic        vda     = 1'b0;
  logic        vpa     = 1'b0;
  logic        rnw     = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  hiaddr_out, reg_rd_data;
  logic        remap_hit, dummy_access, reg_rd_en, hsclk_sel, hold_active;

  remap_clksel_m #(
    .NUM_WIN    (4),
    .ROMSEL_SZ  (4),
    .ROMSEL_ADDR(16'hFE30)
  ) u_dut (
    .cpu_clk     (cpu_clk),
    .resetb      (resetb),
    .addr        (addr),
    .bank_in     (bank_in),
    .vda         (vda),
    .vpa         (vpa),
    .rnw         (rnw),
    .data_in     (data_in),
    .hiaddr_out  (hiaddr_out),
    .remap_hit   (remap_hit),
    .dummy_access(dummy_access),
    .reg_rd_en   (reg_rd_en),
    .reg_rd_data (reg_rd_data),
    .hsclk_sel   (hsclk_sel),
    .hold_active (hold_active)
  );

  always #5 cpu_clk = ~cpu_clk;

  localparam int KHi = 0, KHit = 1, KDummy = 2, KRdEn = 3, KRdData = 4, KHs = 5, KHold = 6;

  typedef struct {
    string      tag;
    int         kind;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] observe(input int kind);
    case (kind)
      KHi:     return hiaddr_out;
      KHit:    return {7'b0, remap_hit};
      KDummy:  return {7'b0, dummy_access};
      KRdEn:   return {7'b0, reg_rd_en};
      KRdData: return reg_rd_data;
      KHs:     return {7'b0, hsclk_sel};
      default: return {7'b0, hold_active};
    endcase
  endfunction

  task automatic want(input string tag, input int kind, input logic [7:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = v;
    sb.push_back(e);
  endtask

  // Compare everything queued for this cycle at the falling edge, then move past the rising edge.
  task automatic step();
    exp_t e;
    @(negedge cpu_clk);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.kind), e.exp);
    end
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic bus(input logic [7:0] b, input logic [15:0] a, input logic da, input logic pa,
                     input logic rw, input logic [7:0] d);
    bank_in = b;
    addr    = a;
    vda     = da;
    vpa     = pa;
    rnw     = rw;
    data_in = d;
  endtask

  task automatic reg_wr(input logic [7:0] off, input logic [7:0] val);
    bus(8'h80, {8'h00, off}, 1'b1, 1'b0, 1'b0, val);
    want("regwr_rden", KRdEn, 8'h00);
    step();
  endtask

  task automatic reg_rd(input string tag, input logic [7:0] off, input logic [7:0] exp);
    bus(8'h80, {8'h00, off}, 1'b1, 1'b0, 1'b1, 8'h00);
    want(tag, KRdData, exp);
    want({tag, "_en"}, KRdEn, 8'h01);
    step();
  endtask

  task automatic rd0(input string tag, input logic [15:0] a, input logic [7:0] hi,
                     input logic hit);
    bus(8'h00, a, 1'b1, 1'b0, 1'b1, 8'h00);
    want({tag, "_hi"}, KHi, hi);
    want({tag, "_hit"}, KHit, {7'b0, hit});
    step();
  endtask

  task automatic wr0(input string tag, input logic [15:0] a, input logic [7:0] d,
                     input logic [7:0] hi, input logic hit);
    bus(8'h00, a, 1'b1, 1'b0, 1'b0, d);
    want({tag, "_hi"}, KHi, hi);
    want({tag, "_hit"}, KHit, {7'b0, hit});
    step();
  endtask

  task automatic fetch_c0(input string tag, input logic hs, input logic hold);
    bus(8'hC0, 16'h1234, 1'b1, 1'b1, 1'b1, 8'h00);
    want({tag, "_hs"}, KHs, {7'b0, hs});
    want({tag, "_hold"}, KHold, {7'b0, hold});
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held: outputs pass bank_in through, clock select low.
    bus(8'h12, 16'h3000, 1'b1, 1'b0, 1'b1, 8'h00);
    want("rst_hi", KHi, 8'h12);
    want("rst_hit", KHit, 8'h00);
    want("rst_hs", KHs, 8'h00);
    want("rst_hold", KHold, 8'h00);
    want("rst_dummy", KDummy, 8'h00);
    step();
    step();
    resetb = 1'b1;

    // Load state, reach HS, then reset asynchronously mid-cycle.
    reg_wr(8'h00, 8'h01);
    reg_wr(8'h10, 8'h70);
    reg_wr(8'h11, 8'hFE);
    reg_wr(8'h12, 8'h80);
    wr0("romsel_pre", 16'hFE30, 8'h07, 8'h00, 1'b0);
    bus(8'hC0, 16'h1234, 1'b1, 1'b1, 1'b1, 8'h00);
    want("pre_dummy", KDummy, 8'h01);
    want("pre_fetch_hs", KHs, 8'h01);
    step();
    reg_rd("pre_status_hs", 8'h02, 8'h01);
    reg_rd("pre_romsel", 8'h03, 8'h07);
    rd0("pre_hit", 16'h3000, 8'hFE, 1'b1);
    bus(8'h00, 16'h3000, 1'b1, 1'b0, 1'b1, 8'h00);
    resetb = 1'b0;
    want("arst_hs", KHs, 8'h00);
    want("arst_hit", KHit, 8'h00);
    want("arst_hi", KHi, 8'h00);
    want("arst_hold", KHold, 8'h00);
    step();
    resetb = 1'b1;
    reg_rd("rst_status", 8'h02, 8'h00);
    reg_rd("rst_ctrl", 8'h00, 8'h00);
    reg_rd("rst_src0", 8'h10, 8'h00);
    reg_rd("rst_cfg0", 8'h12, 8'h00);
    reg_rd("rst_romsel", 8'h03, 8'h00);

    // Single window, page range 0..7.
    reg_wr(8'h10, 8'h70);
    reg_wr(8'h11, 8'hFE);
    reg_wr(8'h12, 8'h90);
    reg_rd("cfg0_rsvd", 8'h12, 8'h80);
    reg_rd("dest0", 8'h11, 8'hFE);
    rd0("w0_3000", 16'h3000, 8'hFE, 1'b1);
    rd0("w0_8000", 16'h8000, 8'h00, 1'b0);
    rd0("w0_lo_edge", 16'h0000, 8'hFE, 1'b1);
    rd0("w0_hi_edge", 16'h7FFF, 8'hFE, 1'b1);
    reg_wr(8'h13, 8'h55);
    reg_rd("unimpl", 8'h13, 8'h00);
    bus(8'h80, 16'h0004, 1'b0, 1'b0, 1'b1, 8'h00);
    want("no_vda_rden", KRdEn, 8'h00);
    want("idle_dummy", KDummy, 8'h00);
    step();

    // Write protect: writes pass through unremapped, reads still hit.
    reg_wr(8'h12, 8'hC0);
    wr0("wp_write", 16'h3000, 8'h11, 8'h00, 1'b0);
    rd0("wp_read", 16'h3000, 8'hFE, 1'b1);
    reg_wr(8'h12, 8'h80);

    // Overlap at page 4: lowest index wins.
    reg_wr(8'h14, 8'h44);
    reg_wr(8'h15, 8'hFD);
    reg_wr(8'h16, 8'h80);
    rd0("ovl_w0", 16'h4000, 8'hFE, 1'b1);
    reg_wr(8'h12, 8'h00);
    rd0("ovl_w1", 16'h4000, 8'hFD, 1'b1);

    // base > limit never matches.
    reg_wr(8'h18, 8'h2A);
    reg_wr(8'h19, 8'h66);
    reg_wr(8'h1A, 8'h80);
    rd0("inv_A000", 16'hA000, 8'h00, 1'b0);
    rd0("inv_2000", 16'h2000, 8'h00, 1'b0);

    // ROMSEL-qualified windows: w3 pages 8..B romval 3, w2 page F romval 5.
    reg_wr(8'h1C, 8'hB8);
    reg_wr(8'h1D, 8'h55);
    reg_wr(8'h1E, 8'hA3);
    reg_wr(8'h18, 8'hFF);
    reg_wr(8'h19, 8'h77);
    reg_wr(8'h1A, 8'hA5);
    rd0("rq_before", 16'h9000, 8'h00, 1'b0);
    wr0("rq_wr3", 16'hFE30, 8'h03, 8'h00, 1'b0);
    rd0("rq_hit3", 16'h9000, 8'h55, 1'b1);
    wr0("rq_wr5_old", 16'hFE30, 8'h05, 8'h00, 1'b0);
    rd0("rq_miss5", 16'h9000, 8'h00, 1'b0);
    rd0("rq_w2_hit", 16'hFE30, 8'h77, 1'b1);
    wr0("rq_wr_oldval", 16'hFE30, 8'hF3, 8'h77, 1'b1);
    reg_rd("romsel_trunc", 8'h03, 8'h03);
    rd0("rq_hit3b", 16'h9000, 8'h55, 1'b1);
    reg_wr(8'h1A, 8'h00);
    reg_wr(8'h1E, 8'h00);

    // Clock select basics (CTRL was cleared by reset).
    fetch_c0("en_off", 1'b0, 1'b0);
    reg_wr(8'h00, 8'h01);
    fetch_c0("hs_fetch", 1'b1, 1'b0);
    reg_rd("status_hs", 8'h02, 8'h01);
    bus(8'h00, 16'h2000, 1'b1, 1'b0, 1'b1, 8'h00);
    want("data_rd_hs", KHs, 8'h00);
    step();
    reg_rd("status_ls", 8'h02, 8'h00);
    fetch_c0("hs_fetch2", 1'b1, 1'b0);
    bus(8'h00, 16'h4000, 1'b1, 1'b0, 1'b1, 8'h00);
    want("remap_rd_hs", KHs, 8'h01);
    want("remap_rd_hi", KHi, 8'hFD);
    step();
    bus(8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h00);
    want("internal_hs", KHs, 8'h01);
    step();

    // HOLD dwell of 3 cycles, then reload during HOLD.
    reg_wr(8'h01, 8'h03);
    reg_rd("hold_reg", 8'h01, 8'h03);
    fetch_c0("h_pre", 1'b1, 1'b0);
    wr0("h_bbcwr", 16'h2000, 8'hAA, 8'h00, 1'b0);
    fetch_c0("h_c1", 1'b0, 1'b1);
    fetch_c0("h_c2", 1'b0, 1'b1);
    fetch_c0("h_c3", 1'b0, 1'b1);
    fetch_c0("h_c4", 1'b1, 1'b0);
    wr0("h_bbcwr2", 16'h2000, 8'hAA, 8'h00, 1'b0);
    fetch_c0("r_c1", 1'b0, 1'b1);
    bus(8'h00, 16'h2000, 1'b1, 1'b0, 1'b0, 8'hBB);
    want("r_reload_hs", KHs, 8'h00);
    want("r_reload_hold", KHold, 8'h01);
    step();
    reg_rd("status_hold", 8'h02, 8'h02);
    fetch_c0("r_c2", 1'b0, 1'b1);
    fetch_c0("r_c3", 1'b0, 1'b1);
    fetch_c0("r_c4", 1'b1, 1'b0);

    // Disabling hsclk_en drops the request on the following cycle.
    reg_wr(8'h00, 8'h00);
    fetch_c0("dis_fetch", 1'b0, 1'b0);
    reg_rd("dis_status", 8'h02, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
